// File: rtl/sr_fetch.sv
// sr_fetch: schoolRISCV fetch stage; owns the PC, issues one-outstanding word fetches
// and presents each instruction with its PC through a valid/ready output register.
module sr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        invalid_instr,
   output logic        halted
);
   typedef enum logic [1:0] {REQ, WAIT, HALT} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_pc, r_req_pc, r_instr, r_instr_pc;
   logic        r_valid, r_drop;
   logic        w_xfer, w_halt, w_redir, w_gnt, w_rsp, w_fill;
   assign w_xfer      = r_valid && instr_ready;
   assign w_halt      = w_xfer && invalid_instr;
   assign w_redir     = redirect && r_state != HALT;
   // only request when the output register is empty or draining, so a fill never overwrites
   assign imem_req    = !rst && r_state == REQ && (!r_valid || instr_ready) && !redirect;
   assign w_gnt       = imem_req && imem_gnt;
   assign w_rsp       = r_state == WAIT && imem_rvalid;
   assign w_fill      = w_rsp && !r_drop && !w_redir;
   assign imem_addr   = r_pc;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign halted      = r_state == HALT;
   always_comb begin
      w_next = r_state;
      if (w_halt)
         w_next = HALT;
      else if (r_state == REQ && w_gnt)
         w_next = WAIT;
      else if (w_rsp)
         w_next = REQ;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= REQ;
         r_pc       <= RESET_PC;
         r_req_pc   <= RESET_PC;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_gnt)
            r_req_pc <= r_pc;
         r_pc <= w_redir ? {redirect_pc[31:2], 2'b00} : w_gnt ? r_pc + 32'd4 : r_pc;
         // a redirect coinciding with the response discards it without arming drop
         r_drop <= w_redir ? ((r_state == WAIT && !imem_rvalid) || w_gnt) : w_rsp ? 1'b0 : r_drop;
         if (w_fill) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_req_pc;
         end
         r_valid <= (w_halt || w_redir) ? 1'b0 : w_fill ? 1'b1 : w_xfer ? 1'b0 : r_valid;
      end
   end
endmodule

// File: tb/tb_sr_fetch.sv
// tb_sr_fetch: scoreboard bench for sr_fetch with a latency-programmable memory model.
module tb_sr_fetch;
   logic        clk = 1'b0;
   logic        rst, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready;
   logic        redirect, invalid_instr, halted, inv_en;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
   int          n_cmp = 0, n_err = 0, lat = 1, cyc = 0;
   logic [31:0] exp_q[$], grants_q[$];
   int          xfer_cyc[$];
   logic        m_g, m_busy = 1'b0;
   logic [31:0] m_a, m_addr;
   int          m_cnt;
   sr_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
      .invalid_instr(invalid_instr), .halted(halted)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign invalid_instr = inv_en && instr_pc == 32'h0000_0108;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // memory: grant decided before the edge, response lat cycles after the grant
   always @(negedge clk) begin
      m_g = imem_req && imem_gnt;
      m_a = imem_addr;
      if (m_g) grants_q.push_back(m_a);
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (m_g) begin
         m_busy = 1'b1;
         m_addr = m_a;
         m_cnt  = lat;
      end
      if (m_busy) begin
         m_cnt--;
         if (m_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = m_addr ^ 32'hA5A5_0000;
            m_busy      = 1'b0;
         end
      end
   end
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready && exp_q.size() > 0) begin
         logic [31:0] p;
         p = exp_q.pop_front();
         chk("xfer_pc", instr_pc, p);
         chk("xfer_instr", instr, p ^ 32'hA5A5_0000);
         xfer_cyc.push_back(cyc);
      end
   end
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      step(2);
      exp_q.delete();
      grants_q.delete();
      xfer_cyc.delete();
      rst = 1'b0;
   endtask
   task automatic wait_drain(input int budget);
      int b = budget;
      while (exp_q.size() > 0 && b > 0) begin
         step();
         b--;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask
   task automatic chk_gnt(input int i, input logic [31:0] exp);
      if (grants_q.size() > i) chk("gnt_addr", grants_q[i], exp);
      else chk("gnt_count", grants_q.size(), i + 1);
   endtask
   initial begin
      rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; inv_en = 1'b0;
      // reset values and zero-wait streaming
      step();
      chk("req_in_rst", imem_req, 0);
      chk("valid_rst", instr_valid, 0);
      chk("pc_rst", instr_pc, 0);
      chk("halted_rst", halted, 0);
      do_reset();
      exp_q = '{32'h100, 32'h104, 32'h108};
      wait_drain(30);
      chk_gnt(0, 32'h100);
      if (xfer_cyc.size() == 3) begin
         chk("gap1", 32'(xfer_cyc[1] - xfer_cyc[0]), 2);
         chk("gap2", 32'(xfer_cyc[2] - xfer_cyc[1]), 2);
      end else chk("xfer_count", xfer_cyc.size(), 3);
      // backpressure
      do_reset();
      exp_q = '{32'h100, 32'h104};
      for (int b = 0; b < 20 && !instr_valid; b++) step();
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_req", imem_req, 0);
         chk("stall_pc", instr_pc, 32'h100);
         chk("stall_instr", instr, 32'h100 ^ 32'hA5A5_0000);
      end
      instr_ready = 1'b1;
      wait_drain(20);
      // redirect while waiting on a slow response
      do_reset();
      lat = 3;
      exp_q = '{32'h100, 32'h200, 32'h204};
      for (int b = 0; b < 30 && grants_q.size() < 2; b++) step();
      chk_gnt(1, 32'h104);
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      chk("redir_addr", imem_addr, 32'h200);
      wait_drain(40);
      chk_gnt(2, 32'h200);
      // redirect coinciding with the response
      do_reset();
      lat = 2;
      exp_q = '{32'h100, 32'h200};
      for (int b = 0; b < 30 && grants_q.size() < 2; b++) step();
      for (int b = 0; b < 10 && !imem_rvalid; b++) step();
      chk("rvalid_seen", imem_rvalid, 1);
      redirect = 1'b1; redirect_pc = 32'h203;
      step();
      redirect = 1'b0;
      wait_drain(30);
      chk_gnt(2, 32'h200);
      // redirect in the would-be grant cycle
      do_reset();
      lat = 1;
      exp_q = '{32'h300, 32'h304};
      redirect = 1'b1; redirect_pc = 32'h300;
      #1;
      chk("req_on_redir", imem_req, 0);
      step();
      redirect = 1'b0;
      wait_drain(30);
      chk_gnt(0, 32'h300);
      // halt on invalid instruction
      do_reset();
      inv_en = 1'b1;
      exp_q = '{32'h100, 32'h104, 32'h108};
      wait_drain(30);
      chk("halted", halted, 1);
      chk("halt_valid", instr_valid, 0);
      for (int i = 0; i < 20; i++) begin
         redirect = (i == 5);
         redirect_pc = 32'h400;
         step();
         chk("halt_req", imem_req, 0);
      end
      chk("halt_still", halted, 1);
      chk("halt_addr", imem_addr, 32'h110);
      inv_en = 1'b0;
      do_reset();
      chk("unhalt", halted, 0);
      exp_q = '{32'h100};
      wait_drain(20);
      // PC wrap
      do_reset();
      exp_q = '{32'hFFFF_FFFC, 32'h0};
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      wait_drain(30);
      chk_gnt(0, 32'hFFFF_FFFC);
      chk_gnt(1, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sr_fetch.md
# sr_fetch

Instruction fetch stage for the schoolRISCV core. It owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake. It presents each fetched instruction, with its PC, to the decode/control stage through a valid/ready output register. It applies PC redirects from the execute side (branch, JAL, JALR) and stops fetching permanently when decode flags an invalid instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address; always equals the internal PC.
- imem_gnt  in  1  request accepted; counts only when imem_req=1.
- imem_rvalid  in  1  response valid; earliest one cycle after the grant.
- imem_rdata  in  32  instruction word returned with imem_rvalid.
- instr_valid  out  1  output register holds an instruction.
- instr  out  32  instruction word; bits [6:0], [14:12], [31:25] feed the decoder opcode, funct3 and funct7 inputs.
- instr_pc  out  32  PC of the presented instruction.
- instr_ready  in  1  consumer accepts; a transfer occurs when instr_valid and instr_ready are both 1.
- redirect  in  1  one-cycle pulse that loads redirect_pc and flushes in-flight work.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and treated as 0.
- invalid_instr  in  1  decoder verdict for the presented instruction; sampled only on a transfer.
- halted  out  1  fetch permanently stopped.

## Operation
- State machine with states REQ, WAIT and HALT. Reset enters REQ.
- Reset values: pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, drop=0, halted=0.
- imem_req is combinational: state==REQ && (!instr_valid || instr_ready) && !redirect. It is 0 in the cycle rst is high.
- REQ, on imem_gnt:
  - Latch req_pc=pc.
  - pc <= pc+4, modulo 2^32.
  - Go to WAIT.
- WAIT, on imem_rvalid:
  - If drop=1: discard the data and clear drop.
  - Otherwise: instr <= imem_rdata, instr_pc <= req_pc, instr_valid <= 1.
  - Go to REQ.
- At most one request is outstanding. Any imem_rvalid outside WAIT is ignored.
- A transfer without a new fill clears instr_valid.
- Redirect (ignored in HALT):
  - pc <= {redirect_pc[31:2], 2'b00} and instr_valid <= 0.
  - If in WAIT, or granted in that same cycle, set drop=1 so the old response is discarded.
  - Redirect together with imem_rvalid: the response is discarded, drop stays 0, and the state returns to REQ.
  - Redirect together with a transfer: the transfer counts; the register is still cleared.
- Before a grant, imem_addr may change on redirect. Instruction memory samples the address only in the grant cycle.
- Halt:
  - A transfer with invalid_instr=1 sends the block to HALT on the next edge.
  - In HALT: instr_valid=0, imem_req=0, halted=1.
  - Any outstanding response is discarded.
  - Only rst leaves HALT.
- Reset mid-operation: all state returns to reset values. A response for a pre-reset request arriving after reset is ignored, because the state is REQ and no grant has occurred.

## Timing
- Grant at cycle T, rvalid at T+k (k≥1): instr_valid=1 from T+k+1.
- The next request can be granted no earlier than T+k+1, so the zero-wait throughput is one instruction per 2 cycles.
- Redirect at cycle R: imem_addr=redirect_pc from R+1, and imem_req is 1 at R+1 if the state is REQ.
- A stalled output (instr_ready=0) holds instr and instr_pc stable and blocks new requests. At most one grant can already be outstanding, and its response fills the register only after the transfer.
  - Correction to the rule above: a request is issued only when the register is empty or draining, so a fill never overwrites valid data.

## Test plan
- Reset with RESET_PC=0x100 and zero-wait memory returning mem[a]=a^0xA5A5_0000, instr_ready=1:
  - imem_req=0 during rst.
  - First grant at address 0x100.
  - Instructions presented with instr_pc 0x100, 0x104, 0x108, spaced 2 cycles apart.
- Backpressure: hold instr_ready=0 for 5 cycles after the first instruction.
  - instr and instr_pc stay at 0x100 and its word.
  - imem_req=0 throughout.
  - Releasing instr_ready leads to 0x104 next.
- Redirect while in WAIT with memory latency 3: redirect_pc=0x200.
  - The pending 0x104 response is dropped.
  - The next presented instr_pc is 0x200.
  - No instruction from 0x104 is ever presented.
- Redirect in the same cycle as imem_rvalid, and separately in the same cycle as a grant:
  - Both old words are discarded.
  - The next grant address is the target.
  - redirect_pc=0x203 yields 0x200.
- invalid_instr=1 on the transfer of instr_pc 0x108:
  - halted=1 on the next cycle.
  - imem_req stays 0 for 20 cycles.
  - Redirect is ignored.
  - rst restarts fetch at RESET_PC.
- PC wrap: redirect to 0xFFFF_FFFC. Grants occur at 0xFFFF_FFFC, then 0x0000_0000.
